// File: rtl/pipelined_prefix_adder.sv
`default_nettype none
// ============================================================================
// Module   : pipelined_prefix_adder
// Purpose  : Parametrised Kogge-Stone prefix adder/subtractor. Pipeline
//            registers between prefix levels are selectable. A valid/ready
//            handshake lets downstream logic stall the datapath without losing
//            operands.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   WIDTH      operand/sum width, power of two, >= 2
//   LEVELS     prefix tree depth, must equal log2(WIDTH)
//   PIPE_MASK  bit k = 1 places a register after prefix level k
// Ports
//   iclk    in   1      clock, rising edge
//   irst    in   1      synchronous active-high reset
//   iA      in   WIDTH  operand A
//   iB      in   WIDTH  operand B
//   icarry  in   1      carry-in (ignored when isub = 1)
//   isub    in   1      1: iA - iB, 0: iA + iB + icarry
//   ivalid  in   1      operands valid
//   oready  out  1      operands accepted this cycle (combinational)
//   iready  in   1      downstream accepts the result this cycle
//   osum    out  WIDTH  result modulo 2^WIDTH
//   ocarry  out  1      carry-out (for subtract: 1 = no borrow)
//   ovalid  out  1      osum/ocarry valid
// Latency  : 2 + popcount(PIPE_MASK) register stages, counting the accepting
//            edge as the first.
// ============================================================================
module pipelined_prefix_adder #(
    parameter int                WIDTH     = 32,
    parameter int                LEVELS    = 5,
    parameter logic [LEVELS-1:0] PIPE_MASK = 5'b01010
) (
    input  logic             iclk,
    input  logic             irst,
    input  logic [WIDTH-1:0] iA,
    input  logic [WIDTH-1:0] iB,
    input  logic             icarry,
    input  logic             isub,
    input  logic             ivalid,
    output logic             oready,
    input  logic             iready,
    output logic [WIDTH-1:0] osum,
    output logic             ocarry,
    output logic             ovalid
);

    // ------------------------------------------------------------------
    // Configuration check: the tree depth must match the operand width.
    // ------------------------------------------------------------------
    if ((WIDTH < 2) || (LEVELS != $clog2(WIDTH)) || (WIDTH != (1 << LEVELS))) begin : g_cfg_error
        $error("pipelined_prefix_adder: WIDTH must be a power of two >= 2 and LEVELS must equal log2(WIDTH)");
    end

    // ------------------------------------------------------------------
    // Global advance enable. The whole pipe moves together; when the
    // output slot is full and not being taken, everything holds.
    // ------------------------------------------------------------------
    logic w_en;

    assign w_en   = iready | ~ovalid;
    assign oready = w_en;

    // ------------------------------------------------------------------
    // Input register. Subtraction is folded in here as A + ~B + 1, so the
    // operation mode travels with its operands and needs no further
    // tracking downstream.
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_cin;
    logic             r_v;

    always_ff @(posedge iclk) begin
        if (irst) begin
            r_v <= 1'b0;
        end else if (w_en) begin
            r_v   <= ivalid;
            r_a   <= iA;
            r_b   <= isub ? ~iB : iB;
            r_cin <= isub | icarry;
        end
    end

    // ------------------------------------------------------------------
    // Inter-level buses. Index k is the input of prefix level k; index
    // LEVELS is the result of the last level. Each element is driven by
    // exactly one continuous assignment.
    //   w_g  : group generate (carry out of bit i, including carry-in)
    //   w_p  : group propagate
    //   w_pb : per-bit half-sum A ^ B', needed again for the final XOR
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] w_g   [0:LEVELS];
    logic [WIDTH-1:0] w_p   [0:LEVELS];
    logic [WIDTH-1:0] w_pb  [0:LEVELS];
    logic             w_cin [0:LEVELS];
    logic             w_v   [0:LEVELS];

    // ------------------------------------------------------------------
    // Stage 1: bitwise generate/propagate. The carry-in acts as generate
    // bit -1; it is absorbed into bit 0 here so the prefix tree itself
    // needs no extra column.
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] w_gen;
    logic [WIDTH-1:0] w_prop;

    assign w_gen  = r_a & r_b;
    assign w_prop = r_a ^ r_b;

    assign w_g[0]   = {w_gen[WIDTH-1:1], w_gen[0] | (w_prop[0] & r_cin)};
    assign w_p[0]   = w_prop;
    assign w_pb[0]  = w_prop;
    assign w_cin[0] = r_cin;
    assign w_v[0]   = r_v;

    // ------------------------------------------------------------------
    // Kogge-Stone black-cell rows, span 1, 2, 4, ... WIDTH/2. Bits below
    // the span already hold their final group value and pass through.
    // ------------------------------------------------------------------
    for (genvar k = 0; k < LEVELS; k++) begin : g_level
        localparam int SPAN = 1 << k;

        logic [WIDTH-1:0] w_g_nx;
        logic [WIDTH-1:0] w_p_nx;

        for (genvar b = 0; b < WIDTH; b++) begin : g_bit
            if (b >= SPAN) begin : g_black
                assign w_g_nx[b] = w_g[k][b] | (w_p[k][b] & w_g[k][b-SPAN]);
                assign w_p_nx[b] = w_p[k][b] & w_p[k][b-SPAN];
            end else begin : g_pass
                assign w_g_nx[b] = w_g[k][b];
                assign w_p_nx[b] = w_p[k][b];
            end
        end

        if (PIPE_MASK[k]) begin : g_reg
            // Registered level: only the valid bit needs a reset value.
            logic [WIDTH-1:0] r_lvl_g;
            logic [WIDTH-1:0] r_lvl_p;
            logic [WIDTH-1:0] r_lvl_pb;
            logic             r_lvl_cin;
            logic             r_lvl_v;

            always_ff @(posedge iclk) begin
                if (irst) begin
                    r_lvl_v <= 1'b0;
                end else if (w_en) begin
                    r_lvl_v   <= w_v[k];
                    r_lvl_g   <= w_g_nx;
                    r_lvl_p   <= w_p_nx;
                    r_lvl_pb  <= w_pb[k];
                    r_lvl_cin <= w_cin[k];
                end
            end

            assign w_g[k+1]   = r_lvl_g;
            assign w_p[k+1]   = r_lvl_p;
            assign w_pb[k+1]  = r_lvl_pb;
            assign w_cin[k+1] = r_lvl_cin;
            assign w_v[k+1]   = r_lvl_v;
        end else begin : g_comb
            assign w_g[k+1]   = w_g_nx;
            assign w_p[k+1]   = w_p_nx;
            assign w_pb[k+1]  = w_pb[k];
            assign w_cin[k+1] = w_cin[k];
            assign w_v[k+1]   = w_v[k];
        end
    end

    // The group propagate of the last row has no consumer.
    logic w_unused_p;

    assign w_unused_p = ^w_p[LEVELS];

    // ------------------------------------------------------------------
    // Output register. Sum bit i = p[i] ^ carry into bit i, where the
    // carry into bit 0 is the carry-in itself.
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] w_sum;

    assign w_sum = w_pb[LEVELS] ^ {w_g[LEVELS][WIDTH-2:0], w_cin[LEVELS]};

    always_ff @(posedge iclk) begin
        if (irst) begin
            ovalid <= 1'b0;
            osum   <= '0;
            ocarry <= 1'b0;
        end else if (w_en) begin
            ovalid <= w_v[LEVELS];
            osum   <= w_sum;
            ocarry <= w_g[LEVELS][WIDTH-1];
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pipelined_prefix_adder.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipelined_prefix_adder
// Purpose  : Self-checking bench. The default 32-bit instance is checked by a
//            scoreboard fed at operand acceptance and drained by a monitor at
//            result acceptance. Two further instances (8-bit unpipelined and
//            64-bit fully pipelined) are checked for latency and result.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipelined_prefix_adder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;

    // Default instance
    logic [31:0] a, b;
    logic        cin, sub, ivalid, iready;
    logic        oready;
    logic [31:0] osum;
    logic        ocarry, ovalid;

    pipelined_prefix_adder dut (
        .iclk(clk), .irst(rst), .iA(a), .iB(b), .icarry(cin), .isub(sub),
        .ivalid(ivalid), .oready(oready), .iready(iready),
        .osum(osum), .ocarry(ocarry), .ovalid(ovalid)
    );

    // 8-bit, no inner pipeline registers
    logic [7:0] a8, b8, sum8;
    logic       cin8, sub8, v8, rdy8, c8, ov8;

    pipelined_prefix_adder #(.WIDTH(8), .LEVELS(3), .PIPE_MASK(3'b000)) dut8 (
        .iclk(clk), .irst(rst), .iA(a8), .iB(b8), .icarry(cin8), .isub(sub8),
        .ivalid(v8), .oready(rdy8), .iready(1'b1),
        .osum(sum8), .ocarry(c8), .ovalid(ov8)
    );

    // 64-bit, every level registered
    logic [63:0] a64, b64, sum64;
    logic        cin64, sub64, v64, rdy64, c64, ov64;

    pipelined_prefix_adder #(.WIDTH(64), .LEVELS(6), .PIPE_MASK(6'b111111)) dut64 (
        .iclk(clk), .irst(rst), .iA(a64), .iB(b64), .icarry(cin64), .isub(sub64),
        .ivalid(v64), .oready(rdy64), .iready(1'b1),
        .osum(sum64), .ocarry(c64), .ovalid(ov64)
    );

    int          n_tests = 0;
    int          n_fail  = 0;
    int          n_pop   = 0;
    logic [32:0] exp_q[$];

    // Reference: {carry, sum} from plain unsigned arithmetic, result in
    // bits [w-1:0] and carry/no-borrow in bit 64.
    function automatic logic [64:0] ref_model(input int w, input logic [63:0] x, input logic [63:0] y,
                                              input logic c, input logic s);
        logic [63:0] mask;
        logic [64:0] full;
        logic [64:0] res;
        mask = (w == 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
        x    = x & mask;
        y    = y & mask;
        if (s) begin
            res[63:0] = (x - y) & mask;
            res[64]   = (x >= y);
        end else begin
            full      = {1'b0, x} + {1'b0, y} + {64'd0, c};
            res[63:0] = full[63:0] & mask;
            res[64]   = full[w];
        end
        return res;
    endfunction

    task automatic check(input string name, input logic [64:0] act, input logic [64:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard drain: a result is consumed on an edge with ovalid & iready.
    task automatic monitor();
        logic [32:0] e;
        forever begin
            @(negedge clk);
            if (!rst && ovalid && iready) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL sb_unexpected: got %0h with empty scoreboard, expected no result", {ocarry, osum});
                end else begin
                    e = exp_q.pop_front();
                    n_pop++;
                    check("sb_result", 65'({ocarry, osum}), 65'(e));
                end
            end
        end
    endtask

    // Present one operation and hold it until accepted; enter and leave
    // 1 time unit after a rising edge.
    task automatic send(input logic [31:0] x, input logic [31:0] y, input logic c, input logic s);
        logic [64:0] r;
        a = x; b = y; cin = c; sub = s; ivalid = 1'b1;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            if (oready) begin
                r = ref_model(32, {32'd0, x}, {32'd0, y}, c, s);
                exp_q.push_back({r[64], r[31:0]});
                @(posedge clk); #1;
                ivalid = 1'b0;
                return;
            end
            @(posedge clk); #1;
        end
        ivalid = 1'b0;
        n_tests++;
        n_fail++;
        $display("FAIL send_timeout: got no oready in 200 cycles, expected acceptance");
    endtask

    // Edges counted from the accepting edge (=1) until ovalid is seen.
    // Returns at a falling edge.
    task automatic wait_valid(output int n);
        n = 1;
        for (int t = 0; t < 50; t++) begin
            @(negedge clk);
            if (ovalid) return;
            @(posedge clk); #1;
            n++;
        end
        n = -1;
    endtask

    task automatic run8(input logic [7:0] x, input logic [7:0] y, input logic c, input logic s);
        logic [64:0] r;
        int          n;
        a8 = x; b8 = y; cin8 = c; sub8 = s; v8 = 1'b1;
        @(negedge clk);
        check("w8_oready", 65'(rdy8), 65'd1);
        @(posedge clk); #1;
        v8 = 1'b0;
        n  = 1;
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            if (ov8) break;
            @(posedge clk); #1;
            n++;
        end
        r = ref_model(8, {56'd0, x}, {56'd0, y}, c, s);
        check("w8_latency", 65'(n), 65'd2);
        check("w8_result", 65'({c8, sum8}), 65'({r[64], r[7:0]}));
        @(posedge clk); #1;
    endtask

    task automatic run64(input logic [63:0] x, input logic [63:0] y, input logic c, input logic s);
        logic [64:0] r;
        int          n;
        a64 = x; b64 = y; cin64 = c; sub64 = s; v64 = 1'b1;
        @(negedge clk);
        check("w64_oready", 65'(rdy64), 65'd1);
        @(posedge clk); #1;
        v64 = 1'b0;
        n   = 1;
        for (int t = 0; t < 30; t++) begin
            @(negedge clk);
            if (ov64) break;
            @(posedge clk); #1;
            n++;
        end
        r = ref_model(64, x, y, c, s);
        check("w64_latency", 65'(n), 65'd8);
        check("w64_result", {c64, sum64}, r);
        @(posedge clk); #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got simulation timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int          n;
        int          pops0;
        logic [31:0] held;

        rst = 1'b1;
        a = '0; b = '0; cin = 1'b0; sub = 1'b0; ivalid = 1'b0; iready = 1'b1;
        a8 = '0; b8 = '0; cin8 = 1'b0; sub8 = 1'b0; v8 = 1'b0;
        a64 = '0; b64 = '0; cin64 = 1'b0; sub64 = 1'b0; v64 = 1'b0;

        fork
            monitor();
        join_none

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset_ovalid", 65'(ovalid), 65'd0);
        check("reset_osum",   65'(osum),   65'd0);
        check("reset_ocarry", 65'(ocarry), 65'd0);
        check("reset_oready", 65'(oready), 65'd1);
        @(posedge clk); #1;

        // 1: carry ripples across every bit
        send(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
        wait_valid(n);
        check("t1_latency", 65'(n), 65'd4);
        check("t1_sum",     65'(osum), 65'h0);
        check("t1_carry",   65'(ocarry), 65'd1);
        @(posedge clk); #1;
        @(negedge clk);
        check("t1_single_pulse", 65'(ovalid), 65'd0);
        @(posedge clk); #1;

        // 2: subtract with borrow (carry-in must be ignored), then without
        send(32'd5, 32'd7, 1'b1, 1'b1);
        wait_valid(n);
        check("t2_sub_borrow_sum",   65'(osum),   65'hFFFF_FFFE);
        check("t2_sub_borrow_carry", 65'(ocarry), 65'd0);
        @(posedge clk); #1;
        send(32'd7, 32'd5, 1'b0, 1'b1);
        wait_valid(n);
        check("t2_sub_sum",   65'(osum),   65'd2);
        check("t2_sub_carry", 65'(ocarry), 65'd1);
        @(posedge clk); #1;
        repeat (2) @(posedge clk);
        #1;

        // 3: 100 back-to-back random operations, mixed add/sub
        pops0 = n_pop;
        fork
            begin
                for (int i = 0; i < 100; i++) begin
                    logic [31:0] x, y;
                    x = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : 32'($urandom);
                    y = ($urandom_range(0, 7) == 0) ? x : 32'($urandom);
                    send(x, y, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
                end
            end
            begin
                int run;
                bit seen;
                run  = 0;
                seen = 1'b0;
                for (int t = 0; t < 400; t++) begin
                    @(negedge clk);
                    if (ovalid) begin
                        seen = 1'b1;
                        run++;
                    end else if (seen) begin
                        break;
                    end
                end
                check("t3_consecutive_valids", 65'(run), 65'd100);
            end
        join
        check("t3_results_popped", 65'(n_pop - pops0), 65'd100);
        @(posedge clk); #1;

        // 4: backpressure with three operations in flight
        iready = 1'b0;
        send(32'($urandom), 32'($urandom), 1'b1, 1'b0);
        send(32'($urandom), 32'($urandom), 1'b0, 1'b1);
        send(32'($urandom), 32'($urandom), 1'b1, 1'b0);
        wait_valid(n);
        check("t4_output_arrived", 65'(n > 0), 65'd1);
        held = osum;
        @(posedge clk); #1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("t4_stall_oready", 65'(oready), 65'd0);
            check("t4_stall_ovalid", 65'(ovalid), 65'd1);
            check("t4_stall_osum",   65'(osum),   65'(held));
            @(posedge clk); #1;
        end
        iready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t4_drain_consecutive", 65'(ovalid), 65'd1);
            @(posedge clk); #1;
        end
        @(negedge clk);
        check("t4_drain_done",  65'(ovalid), 65'd0);
        check("t4_no_leftover", 65'(exp_q.size()), 65'd0);
        @(posedge clk); #1;

        // 5: reset while stalled with operations in flight
        iready = 1'b0;
        send(32'($urandom), 32'($urandom), 1'b0, 1'b0);
        send(32'($urandom), 32'($urandom), 1'b1, 1'b1);
        send(32'($urandom), 32'($urandom), 1'b1, 1'b0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_q.delete();
        @(negedge clk);
        check("t5_ovalid", 65'(ovalid), 65'd0);
        check("t5_osum",   65'(osum),   65'd0);
        check("t5_ocarry", 65'(ocarry), 65'd0);
        check("t5_oready", 65'(oready), 65'd1);
        @(posedge clk); #1;
        iready = 1'b1;
        n = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (ovalid) n++;
            @(posedge clk); #1;
        end
        check("t5_no_stale", 65'(n), 65'd0);

        // 6: other configurations
        run8(8'h80, 8'h80, 1'b1, 1'b0);
        run8(8'h03, 8'h05, 1'b0, 1'b1);
        run8(8'hFF, 8'hFF, 1'b1, 1'b1);
        for (int i = 0; i < 6; i++)
            run8(8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        run64(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0);
        run64(64'd0, 64'd1, 1'b0, 1'b1);
        for (int i = 0; i < 6; i++)
            run64({32'($urandom), 32'($urandom)}, {32'($urandom), 32'($urandom)},
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pipelined_prefix_adder.md
Name: pipelined_prefix_adder

Overview:
Parametrised, pipelined Kogge-Stone prefix adder/subtractor, replacing the fixed combinational 32-bit prefix adder in the GOST round datapath.
- Width and the placement of pipeline registers between prefix levels are set by parameters.
- Adds carry-in, carry-out and a subtract mode.
- Carries a valid/ready handshake so the round controller can stall the datapath without losing operands.

Parameters:
WIDTH, 32, operand/sum width in bits; power of two, >= 2.
LEVELS, 5, prefix tree depth; must equal log2(WIDTH).
PIPE_MASK, 5'b01010, LEVELS-bit mask; bit k=1 inserts a register after prefix level k (level 0 = first black-cell row).

Ports:
iclk  input  1  clock; all registers rise-edge.
irst  input  1  synchronous active-high reset.
iA  input  WIDTH  operand A.
iB  input  WIDTH  operand B.
icarry  input  1  carry-in; ignored when isub=1.
isub  input  1  1: compute iA - iB (two's complement); 0: iA + iB + icarry.
ivalid  input  1  operands valid this cycle.
oready  output  1  adder accepts operands this cycle.
iready  input  1  downstream accepts the result this cycle.
osum  output  WIDTH  result modulo 2^WIDTH.
ocarry  output  1  carry-out; for subtract, 1 means no borrow (iA >= iB unsigned).
ovalid  output  1  osum/ocarry valid.

Behaviour:
- Stage structure:
  - Input register (always present) captures iA, B' = isub ? ~iB : iB, cin' = isub ? 1 : icarry, and ivalid.
  - Stage 1 computes bitwise g = A&B', p = A^B'.
  - LEVELS Kogge-Stone black-cell rows follow, at span 1, 2, 4, ... WIDTH/2. Row k registers its (G,P) vectors, p, and the valid bit when PIPE_MASK[k]=1.
  - Carry-in enters as generate bit −1, i.e. G[-1]=cin'.
  - Output register (always present) holds osum = p ^ {G[WIDTH-2:0], cin'}, ocarry = G[WIDTH-1] (carry including cin'), and ovalid.
- Latency: LAT = 2 + popcount(PIPE_MASK) cycles from the accepting edge to ovalid=1. Default is 4.
- Throughput: one operation per cycle when unstalled.
- Handshake:
  - Global advance enable en = iready | ~ovalid. oready = en, combinational.
  - Operands transfer on an edge where ivalid & oready.
  - The result transfers on an edge where ovalid & iready.
  - When en=0, every pipeline register, valid bits included, holds its value; osum/ocarry/ovalid stay stable until accepted.
  - Bubbles (valid=0 slots) propagate and are not collapsed.
  - ivalid=0 with en=1 loads a bubble. Data registers may load don't-care, but ovalid must be 0 for that slot.
- Reset:
  - irst=1 at an edge clears all valid bits and clears osum and ocarry to 0. Data registers inside the pipe need no reset.
  - irst overrides en: in-flight operations are discarded even during a stall.
  - oready is 1 on the cycle after reset.
- Arithmetic rules:
  - Results wrap modulo 2^WIDTH. No overflow flag.
  - isub applies per operation and travels with its operands, so mixed add/sub streams are legal back-to-back.
- Simultaneous events:
  - Output accepted while a new input is accepted in the same cycle: both happen, and the pipe shifts by one.
  - ovalid=1 with iready=0 while ivalid=1: oready=0, and the input is not taken.
- Elaboration: PIPE_MASK=0 gives LAT=2. Mismatched LEVELS/WIDTH is a configuration error; flag it with a generate-time check.

Test Plan:
1. Defaults, iready=1. Drive A=32'hFFFFFFFF, B=32'h00000001, icarry=0, isub=0. Required: after exactly 4 cycles, osum=32'h00000000, ocarry=1, ovalid=1 for one cycle.
2. Subtract. A=32'h00000005, B=32'h00000007, isub=1. Required: osum=32'hFFFFFFFE, ocarry=0. Then A=7, B=5: osum=2, ocarry=1.
3. Back-to-back stream of 100 random add/sub/carry-in operations, iready=1. Required: one result per cycle, in order, each equal to the reference model mod 2^32 with its carry-out; 100 ovalid pulses.
4. Backpressure. Send 3 ops, hold iready=0 for 6 cycles, then release. Required:
   - oready=0 once ovalid=1; osum is stable throughout the stall.
   - No op is lost or duplicated; the 3 results emerge on consecutive cycles after release.
5. Reset mid-flight. Assert irst for 1 cycle with 3 ops in the pipe and iready=0. Required: next cycle ovalid=0, osum=0, ocarry=0, oready=1; no stale result ever appears.
6. Parameter sweep with a random reference check:
   - WIDTH=8, LEVELS=3, PIPE_MASK=3'b000: latency 2.
   - WIDTH=64, LEVELS=6, PIPE_MASK=6'b111111: latency 8.
   - Example check (WIDTH=8): A=8'h80, B=8'h80, icarry=1 gives osum=8'h01, ocarry=1.
